// File: rtl/load_align_unit.sv
// load_align_unit: RV64/RV32 load data path between the LSU and data memory.
// Fetches the aligned word(s) covering a load, shifts the addressed bytes
// down, and sign/zero-extends them per funct3. Loads that straddle a word
// boundary are split into two memory beats.
// Optional feature macro: LOAD_MISALIGN_TRAP_EN. When defined, loads whose
// offset is not a multiple of their size are rejected with rsp_err_o and
// never reach memory, so the second-beat path is not built.
module load_align_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_funct3_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  localparam int BYTES = XLEN / 8;
  localparam int OFS_W = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_e;

  state_e              state_q, state_d;
  logic [OFS_W-1:0]    ofs_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [XLEN-1:0]     data_q;
  logic                err_q;
`ifndef LOAD_MISALIGN_TRAP_EN
  logic                cross_q;
  logic [XLEN-1:0]     beat0_q;
`endif

  // Request decode (valid only while IDLE)
  logic [OFS_W-1:0]    req_ofs;
  logic [3:0]          req_size;
  logic                req_illegal;
  logic                req_reject;
`ifdef LOAD_MISALIGN_TRAP_EN
  logic                req_mis;
`else
  logic [4:0]          req_end;
  logic                req_cross;
`endif

  // Classify the incoming request: size, offset, boundary crossing, legality
  always_comb begin
    req_ofs     = req_addr_i[OFS_W-1:0];
    req_size    = 4'd1 << req_funct3_i[1:0];
    req_illegal = (req_funct3_i == 3'd7) ||
                  ((XLEN == 32) && ((req_funct3_i == 3'd3) || (req_funct3_i == 3'd6)));
`ifdef LOAD_MISALIGN_TRAP_EN
    req_mis     = (4'(req_ofs) & (req_size - 4'd1)) != 4'd0;
    req_reject  = req_illegal || req_mis;
`else
    req_end     = 5'(req_ofs) + 5'(req_size);
    req_cross   = req_end > 5'(BYTES);
    req_reject  = req_illegal;
`endif
  end

  // Extraction: shift the beat pair down by the byte offset, then extend
  logic [XLEN-1:0]     raw;
  logic [XLEN-1:0]     ext;
  logic                sgn;
`ifndef LOAD_MISALIGN_TRAP_EN
  logic [2*XLEN-1:0]   pair;
`endif

  // Build the extended result from the beat(s) arriving this cycle
  always_comb begin
`ifdef LOAD_MISALIGN_TRAP_EN
    raw  = mem_rdata_i >> {ofs_q, 3'b000};
`else
    // second beat only exists in RD1; a single-beat load sees zeros above
    pair = (state_q == RD1) ? {mem_rdata_i, beat0_q} : {{XLEN{1'b0}}, mem_rdata_i};
    raw  = XLEN'(pair >> {ofs_q, 3'b000});
`endif
    case (f3_q[1:0])
      2'd0:    sgn = raw[7];
      2'd1:    sgn = raw[15];
      2'd2:    sgn = raw[31];
      default: sgn = raw[XLEN-1];
    endcase
    ext = '0;
    for (int b = 0; b < BYTES; b++)
      ext[8*b +: 8] = (b < (1 << f3_q[1:0])) ? raw[8*b +: 8] : {8{sgn & ~f3_q[2]}};
  end

  // State register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid_i) state_d = req_reject ? RESP : RD0;
      RD0: if (mem_rvalid_i) begin
`ifdef LOAD_MISALIGN_TRAP_EN
        state_d = RESP;
`else
        state_d = cross_q ? RD1 : RESP;
`endif
      end
`ifndef LOAD_MISALIGN_TRAP_EN
      RD1:  if (mem_rvalid_i) state_d = RESP;
`endif
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; data outputs come straight from registers
  always_comb begin
    req_ready_o = (state_q == IDLE);
    mem_req_o   = (state_q == RD0) || (state_q == RD1);
    rsp_valid_o = (state_q == RESP);
    mem_addr_o  = mem_addr_q;
    rsp_data_o  = data_q;
    rsp_err_o   = err_q;
  end

  // Datapath registers: latch request, track beat address, capture result
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ofs_q      <= '0;
      f3_q       <= '0;
      mem_addr_q <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
`ifndef LOAD_MISALIGN_TRAP_EN
      cross_q    <= 1'b0;
      beat0_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          ofs_q <= req_ofs;
          f3_q  <= req_funct3_i;
`ifndef LOAD_MISALIGN_TRAP_EN
          cross_q <= req_cross;
`endif
          if (req_reject) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end else begin
            mem_addr_q <= {req_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
          end
        end
        RD0: if (mem_rvalid_i) begin
`ifdef LOAD_MISALIGN_TRAP_EN
          data_q <= ext;
          err_q  <= 1'b0;
`else
          beat0_q <= mem_rdata_i;
          if (cross_q) begin
            // next word; wraps modulo 2^ADDR_W
            mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
          end else begin
            data_q <= ext;
            err_q  <= 1'b0;
          end
`endif
        end
`ifndef LOAD_MISALIGN_TRAP_EN
        RD1: if (mem_rvalid_i) begin
          data_q <= ext;
          err_q  <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit (XLEN=64): table of directed loads, hand-written
// reset/wrap sequences, and random loads against a byte-wise memory model.
module tb_load_align_unit;
  localparam int XLEN = 64, ADDR_W = 64;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [63:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic        mem_req, mem_rvalid;
  logic [63:0] mem_addr, mem_rdata;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [63:0] rsp_data;

  logic        rv_resp = 1'b0, rv_inj = 1'b0;
  logic [63:0] rd_resp = '0, rd_inj = '0;
  assign mem_rvalid = rv_resp | rv_inj;
  assign mem_rdata  = rv_inj ? rd_inj : rd_resp;

  load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_funct3_i(req_funct3),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  function automatic logic [63:0] mem_word(input logic [63:0] w);
    if (w == 64'h100) return 64'h8877665544332211;
    if (w == 64'h108) return 64'h00FFEEDDCCBBAA99;
    return (w * 64'h9E3779B97F4A7C15) ^ 64'h5DEECE66D1234567;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    logic [63:0] w;
    w = mem_word({a[63:3], 3'b000});
    return w[8*a[2:0] +: 8];
  endfunction

  function automatic bit is_mis(input logic [63:0] a, input logic [2:0] f3);
    int sz;
    sz = 1 << f3[1:0];
    return (a % sz) != 0;
  endfunction

  // Expected result: gather SIZE bytes one at a time, then extend
  function automatic logic [63:0] model(input logic [63:0] a, input logic [2:0] f3,
                                        output logic err);
    int sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    err = 1'b1;
    if (f3 == 3'd7) return 64'd0;
`ifdef LOAD_MISALIGN_TRAP_EN
    if (is_mis(a, f3)) return 64'd0;
`endif
    err = 1'b0;
    v = 64'd0;
    for (int i = 0; i < sz; i++) v = v | (64'(mem_byte(a + 64'(i))) << (8*i));
    if (sz < 8 && !f3[2] && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v;
  endfunction

  function automatic int exp_beats(input logic [63:0] a, input logic [2:0] f3);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'd7) return 0;
`ifdef LOAD_MISALIGN_TRAP_EN
    if (is_mis(a, f3)) return 0;
`endif
    return (int'(a % 8) + sz > 8) ? 2 : 1;
  endfunction

  // ---------------- memory responder ----------------
  int          mem_dly = 0;
  bit          rnd_dly = 0;
  logic [63:0] beat_q[$];
  int          rv_cyc = 0;

  initial begin
    bit          busy;
    int          cnt;
    logic [63:0] a;
    busy = 0; cnt = 0; a = '0;
    forever begin
      @(negedge clk);
      rv_resp = 1'b0;
      if (reset) busy = 0;
      else begin
        if (!busy && mem_req) begin
          busy = 1; a = mem_addr; beat_q.push_back(a);
          cnt = rnd_dly ? int'($urandom_range(0, 4)) : mem_dly;
        end
        if (busy) begin
          if (cnt == 0) begin
            rv_resp = 1'b1; rd_resp = mem_word(a); busy = 0; rv_cyc = cyc;
          end else cnt--;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic do_load(input logic [63:0] a, input logic [2:0] f3, input int hold,
                         output logic [63:0] d, output logic e,
                         output bit lat_ok, output bit stab_ok, output bit tmo);
    int n;
    tmo = 0; lat_ok = 1; stab_ok = 1; d = 'x; e = 1'bx;
    beat_q.delete();
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_addr = a; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 64'(~a); req_funct3 = 3'($urandom);
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) begin tmo = 1; return; end
    d = rsp_data; e = rsp_err;
    if (beat_q.size() > 0 && cyc != rv_cyc + 1) lat_ok = 0;
    if (beat_q.size() == 0 && n != 0) lat_ok = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_data !== d || rsp_err !== e) stab_ok = 0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (rsp_valid) stab_ok = 0;
  endtask

  // Run one load and compare against expectations
  task automatic run_chk(input string nm, input logic [63:0] a, input logic [2:0] f3,
                         input int hold, input logic [63:0] xd, input logic xe);
    logic [63:0] d;
    logic        e;
    bit          lat_ok, stab_ok, tmo;
    int          nb;
    logic [63:0] w0;
    do_load(a, f3, hold, d, e, lat_ok, stab_ok, tmo);
    chk({nm, "_timeout"}, 64'(tmo), 64'd0);
    chk({nm, "_data"}, d, xd);
    chk({nm, "_err"}, 64'(e), 64'(xe));
    nb = exp_beats(a, f3);
    chk({nm, "_beats"}, 64'(beat_q.size()), 64'(nb));
    w0 = {a[63:3], 3'b000};
    if (nb >= 1 && beat_q.size() >= 1) chk({nm, "_addr0"}, beat_q[0], w0);
    if (nb == 2 && beat_q.size() >= 2) chk({nm, "_addr1"}, beat_q[1], w0 + 64'd8);
    chk({nm, "_latency"}, 64'(lat_ok), 64'd1);
    chk({nm, "_stable"}, 64'(stab_ok), 64'd1);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [2:0]  f3;
    int          hold;
    int          dly;
    logic [63:0] xd;
    logic        xe;
  } vec_t;

  vec_t tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] xd, a;
    logic        xe;
    logic [2:0]  f3;
    int          n;

    tbl[0]  = '{64'h100, 3'd3, 0, 0, 64'h8877665544332211, 1'b0};
    tbl[1]  = '{64'h107, 3'd0, 0, 1, 64'hFFFFFFFFFFFFFF88, 1'b0};
    tbl[2]  = '{64'h107, 3'd4, 1, 0, 64'h0000000000000088, 1'b0};
    tbl[3]  = '{64'h106, 3'd2, 0, 2, 64'hFFFFFFFFAA998877, 1'b0};
    tbl[4]  = '{64'h100, 3'd7, 5, 0, 64'h0, 1'b1};
    tbl[5]  = '{64'h100, 3'd3, 0, 7, 64'h8877665544332211, 1'b0};
    tbl[6]  = '{64'h102, 3'd5, 0, 0, 64'h0000000000004433, 1'b0};
    tbl[7]  = '{64'h10E, 3'd1, 0, 3, 64'h00000000000000FF, 1'b0};
    tbl[8]  = '{64'h10C, 3'd2, 2, 0, 64'h0000000000FFEEDD, 1'b0};
    tbl[9]  = '{64'h104, 3'd6, 0, 0, 64'h0000000088776655, 1'b0};
    tbl[10] = '{64'h104, 3'd2, 0, 1, 64'hFFFFFFFF88776655, 1'b0};
    tbl[11] = '{64'h104, 3'd3, 0, 7, 64'hCCBBAA9988776655, 1'b0};
    tbl[12] = '{64'h109, 3'd0, 0, 0, 64'hFFFFFFFFFFFFFFAA, 1'b0};
    tbl[13] = '{64'h10F, 3'd4, 0, 0, 64'h0000000000000000, 1'b0};
    tbl[14] = '{64'h107, 3'd1, 0, 0, 64'hFFFFFFFFFFFF9988, 1'b0};
    tbl[15] = '{64'h101, 3'd5, 0, 4, 64'h0000000000003322, 1'b0};

    // reset state
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // directed table
    for (int i = 0; i < 16; i++) begin
      xd = tbl[i].xd; xe = tbl[i].xe;
`ifdef LOAD_MISALIGN_TRAP_EN
      if (is_mis(tbl[i].addr, tbl[i].f3)) begin xd = 64'd0; xe = 1'b1; end
`endif
      mem_dly = tbl[i].dly;
      run_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].f3, tbl[i].hold, xd, xe);
    end

    // address wrap on the second beat
    mem_dly = 1;
    a = 64'hFFFFFFFFFFFFFFFC;
    xd = model(a, 3'd3, xe);
    run_chk("wrap", a, 3'd3, 0, xd, xe);

    // reset while waiting in RD0, then a stale rvalid after release
    mem_dly = 20;
    req_valid = 1'b1; req_addr = 64'h106; req_funct3 = 3'd1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rd0_mem_req", 64'(mem_req), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_mem_addr", mem_addr, 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_rsp_data", rsp_data, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    rv_inj = 1'b1; rd_inj = 64'hDEADBEEFCAFEF00D;
    @(posedge clk); #1;
    rv_inj = 1'b0;
    @(posedge clk); #1;
    chk("stale_req_ready", 64'(req_ready), 64'd1);
    chk("stale_mem_req", 64'(mem_req), 64'd0);
    chk("stale_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("stale_rsp_data", rsp_data, 64'd0);
    mem_dly = 0;
    run_chk("post_rst_lhu", 64'h106, 3'd5, 0, 64'h0000000000008877, 1'b0);

    // random loads against the model
    rnd_dly = 1;
    for (int i = 0; i < 150; i++) begin
      n = int'($urandom_range(0, 7));
      if (n == 0) a = 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15));
      else if (n < 4) a = 64'h100 + 64'($urandom_range(0, 31));
      else a = {32'h0, $urandom};
      f3 = 3'($urandom_range(0, 7));
      xd = model(a, f3, xe);
      run_chk($sformatf("rnd%0d", i), a, f3, int'($urandom_range(0, 2)), xd, xe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
